// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel line-buffer datapath: pad-field encoding and a pad helper.
package sobel_pkg;

  typedef logic [1:0] pad_t;

  localparam pad_t PAD_NONE  = 2'b00;
  localparam pad_t PAD_FIRST = 2'b01;
  localparam pad_t PAD_LAST  = 2'b10;

  // First wins when a dimension is only one element long.
  function automatic pad_t pad_of(input logic is_first, input logic is_last);
    if (is_first) return PAD_FIRST;
    if (is_last) return PAD_LAST;
    return PAD_NONE;
  endfunction

endpackage

// File: rtl/bank_rotator.sv
// Tracks which line-buffer bank holds the oldest window row and maps window rows to banks.
module bank_rotator
  import sobel_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned SEL_WD    = $clog2(NUM_BANKS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        advance_i,
  output logic [NUM_BANKS*SEL_WD-1:0] sel_o
);

  localparam logic [SEL_WD-1:0] TOP_MAX = SEL_WD'(NUM_BANKS - 1);

  logic [SEL_WD-1:0] top_q, top_d;

  always_comb begin
    top_d = top_q;
    if (clear_i) begin
      top_d = '0;
    end else if (advance_i) begin
      top_d = (top_q == TOP_MAX) ? '0 : top_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      top_q <= '0;
    end else begin
      top_q <= top_d;
    end
  end

  // Bank count need not be a power of two, so wrap with an explicit compare.
  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (32'(top_q) + i >= NUM_BANKS) begin
        sel_o[i*SEL_WD +: SEL_WD] = SEL_WD'(32'(top_q) + i - NUM_BANKS);
      end else begin
        sel_o[i*SEL_WD +: SEL_WD] = SEL_WD'(32'(top_q) + i);
      end
    end
  end

endmodule

// File: rtl/line_buf_rd_ctrl.sv
// Line-buffer read controller: walks (row, col) over a frame and drives per-bank reads.
// Row padding flags are built only when RD_CTRL_ROW_PAD_EN is defined.
module line_buf_rd_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned NUM_BANKS = 3,
  localparam int unsigned COL_WD   = $clog2(IMG_W),
  localparam int unsigned ROW_WD   = $clog2(IMG_H),
  localparam int unsigned SEL_WD   = $clog2(NUM_BANKS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sof_i,
  input  logic                        rd_en_i,
  output logic                        rd_ready_o,
  output logic [NUM_BANKS-1:0]        bank_en_o,
  output logic [NUM_BANKS*COL_WD-1:0] bank_addr_o,
  output logic [NUM_BANKS*SEL_WD-1:0] bank_sel_o,
  output logic [1:0]                  col_pad_o,
  output logic [1:0]                  row_pad_o,
  output logic                        rd_valid_o,
  output logic                        frame_done_o
);

  localparam logic [COL_WD-1:0] COL_MAX = COL_WD'(IMG_W - 1);
  localparam logic [ROW_WD-1:0] ROW_MAX = ROW_WD'(IMG_H - 1);

  logic [COL_WD-1:0]           col_q, col_d, addr_q;
  logic [ROW_WD-1:0]           row_q, row_d;
  logic                        bubble_q, valid_q, done_q;
  logic [NUM_BANKS*SEL_WD-1:0] sel_q, rot_sel;
  pad_t                        col_pad_q;
  logic                        accept, col_last, row_last, line_wrap, frame_end;

  assign rd_ready_o = ~bubble_q;
  assign accept     = rd_en_i & rd_ready_o & ~sof_i;
  assign col_last   = (col_q == COL_MAX);
  assign row_last   = (row_q == ROW_MAX);
  assign line_wrap  = accept & col_last;
  assign frame_end  = line_wrap & row_last;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (sof_i) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  bank_rotator #(
    .NUM_BANKS (NUM_BANKS),
    .SEL_WD    (SEL_WD)
  ) u_bank_rotator (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (sof_i | frame_end),
    .advance_i (line_wrap),
    .sel_o     (rot_sel)
  );

  // Rotator output is sampled before the wrap takes effect, so the read reports its own line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q     <= '0;
      row_q     <= '0;
      bubble_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      col_pad_q <= PAD_NONE;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        sel_q[i*SEL_WD +: SEL_WD] <= SEL_WD'(i);
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      bubble_q <= line_wrap;
      valid_q  <= accept;
      done_q   <= frame_end;
      if (accept) begin
        addr_q    <= col_q;
        sel_q     <= rot_sel;
        col_pad_q <= pad_of(col_q == '0, col_last);
      end
    end
  end

`ifdef RD_CTRL_ROW_PAD_EN
  pad_t row_pad_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_pad_q <= PAD_NONE;
    end else if (accept) begin
      row_pad_q <= pad_of(row_q == '0, row_last);
    end
  end

  assign row_pad_o = row_pad_q;
`else
  assign row_pad_o = PAD_NONE;
`endif

  assign bank_en_o    = {NUM_BANKS{valid_q}};
  assign bank_addr_o  = {NUM_BANKS{addr_q}};
  assign bank_sel_o   = sel_q;
  assign col_pad_o    = col_pad_q;
  assign rd_valid_o   = valid_q;
  assign frame_done_o = done_q;

endmodule
